// File: rtl/systolic_result_drain_if.sv
// Capture and result-stream bundle for systolic_result_drain.
// The design drives through the master modport; upstream and downstream use slave.
interface systolic_result_drain_if #(
  parameter int ACC_W = 32,
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int OUT_W = 16
) ();
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic                      cap_valid;
  logic                      cap_ready;
  logic [M*N*ACC_W-1:0]      mat_in;
  logic signed [OUT_W-1:0]   m_data;
  logic                      m_valid;
  logic                      m_ready;
  logic [RW-1:0]             m_row;
  logic [CW-1:0]             m_col;
  logic                      m_last;
  logic                      m_sat;

  modport master (
    input  cap_valid, mat_in, m_ready,
    output cap_ready, m_data, m_valid, m_row, m_col, m_last, m_sat
  );

  modport slave (
    output cap_valid, mat_in, m_ready,
    input  cap_ready, m_data, m_valid, m_row, m_col, m_last, m_sat
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Ping-pong snapshot of the systolic accumulator matrix, drained row-major as a
// saturated valid/ready stream with row/col tags, last flag and frame counter.
module systolic_result_drain #(
  parameter int ACC_W = 32,
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int OUT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  systolic_result_drain_if.master    bus,
  output logic                       busy,
  output logic [CNT_W-1:0]           frame_count
);
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (M * N > 1) ? $clog2(M * N) : 1;

  // With OUT_W == ACC_W these bounds are the full ACC_W range, so nothing clips.
  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  // Returns {clipped, value}.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > MAX_V)      return {1'b1, MAX_V[OUT_W-1:0]};
    else if (v < MIN_V) return {1'b1, MIN_V[OUT_W-1:0]};
    else                return {1'b0, v[OUT_W-1:0]};
  endfunction

  logic signed [ACC_W-1:0] bank [2][M*N];
  logic [1:0]              full;
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [RW-1:0]           row;
  logic [CW-1:0]           col;
  logic [KW-1:0]           idx;

  logic                    cap_fire;
  logic                    xfer;
  logic                    at_last;
  logic signed [ACC_W-1:0] elem;
  logic [OUT_W:0]          sat_res;

  assign at_last       = (row == RW'(M - 1)) && (col == CW'(N - 1));
  assign bus.cap_ready = !rst && !full[wr_ptr];
  assign cap_fire      = bus.cap_valid && bus.cap_ready;
  assign xfer          = bus.m_valid && bus.m_ready;

  // Output decode: purely from registered bank, pointer and index state.
  assign elem        = bank[rd_ptr][idx];
  assign sat_res     = saturate(elem);
  assign bus.m_valid = full[rd_ptr] && !rst;
  assign bus.m_data  = bus.m_valid ? sat_res[OUT_W-1:0] : '0;
  assign bus.m_sat   = bus.m_valid && sat_res[OUT_W];
  assign bus.m_last  = bus.m_valid && at_last;
  assign bus.m_row   = rst ? '0 : row;
  assign bus.m_col   = rst ? '0 : col;
  assign busy        = (full[0] | full[1]) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      full        <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      row         <= '0;
      col         <= '0;
      idx         <= '0;
      frame_count <= '0;
    end else begin
      if (cap_fire) wr_ptr <= !wr_ptr;
      // Capture and release always target different banks, so both may fire.
      for (int b = 0; b < 2; b++) begin
        if (cap_fire && wr_ptr == 1'(b))
          full[b] <= 1'b1;
        else if (xfer && at_last && rd_ptr == 1'(b))
          full[b] <= 1'b0;
      end
      if (xfer) begin
        if (at_last) begin
          row         <= '0;
          col         <= '0;
          idx         <= '0;
          rd_ptr      <= !rd_ptr;
          frame_count <= frame_count + 1'b1;
        end else begin
          idx <= idx + 1'b1;
          if (col == CW'(N - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end

  // Bank storage carries no reset; the full flags alone qualify its contents.
  always_ff @(posedge clk) begin
    if (cap_fire) begin
      for (int k = 0; k < M * N; k++)
        bank[wr_ptr][k] <= bus.mat_in[k*ACC_W +: ACC_W];
    end
  end
endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: drain order, backpressure, ping-pong,
// saturation, mid-stream reset and frame counter wrap (CNT_W=2).
module tb_systolic_result_drain;
  localparam int ACC_W = 32;
  localparam int M     = 4;
  localparam int N     = 4;
  localparam int OUT_W = 16;
  localparam int CNT_W = 2;
  localparam int E     = M * N;

  logic             clk = 1'b0;
  logic             rst;
  logic             busy;
  logic [CNT_W-1:0] frame_count;

  int errors = 0;
  int checks = 0;
  int elems [E];
  logic [15:0] exp_d [$];
  bit          exp_s [$];

  systolic_result_drain_if #(.ACC_W(ACC_W), .M(M), .N(N), .OUT_W(OUT_W)) bus ();

  systolic_result_drain #(
    .ACC_W(ACC_W), .M(M), .N(N), .OUT_W(OUT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [E*ACC_W-1:0] pack();
    logic [E*ACC_W-1:0] m;
    for (int k = 0; k < E; k++) m[k*ACC_W +: ACC_W] = elems[k];
    return m;
  endfunction

  task automatic fill(input int v);
    for (int k = 0; k < E; k++) elems[k] = v;
  endtask

  task automatic push_exp(input logic [15:0] d, input bit s);
    exp_d.push_back(d);
    exp_s.push_back(s);
  endtask

  task automatic push_all(input int v);
    for (int k = 0; k < E; k++) push_exp(16'(v), 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cap_valid = 1'b1;
    bus.m_ready = 1'b1;
    #1;
    check("rst_cap_ready", bus.cap_ready, 0);
    check("rst_m_valid", bus.m_valid, 0);
    step();
    step();
    check("rst_m_valid2", bus.m_valid, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_m_sat", bus.m_sat, 0);
    check("rst_busy", busy, 0);
    check("rst_m_data", $unsigned(bus.m_data), 0);
    check("rst_rowcol", {bus.m_row, bus.m_col}, 0);
    bus.cap_valid = 1'b0;
    bus.m_ready = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_cnt", frame_count, 0);
    check("post_rst_cap_ready", bus.cap_ready, 1);
    exp_d.delete();
    exp_s.delete();
  endtask

  task automatic capture();
    int w = 0;
    bus.mat_in = pack();
    bus.cap_valid = 1'b1;
    while (!bus.cap_ready && w < 100) begin
      step();
      w++;
    end
    if (w >= 100) check("cap_timeout", 1, 0);
    step();
    bus.cap_valid = 1'b0;
  endtask

  // mode 0: ready always high (also checks no bubble); mode 1: ready 1,0,0,1 repeating
  task automatic drain(input int n, input int mode);
    int b = 0;
    int c = 0;
    bit stalled = 0;
    logic [15:0] pd = '0;
    logic [3:0]  prc = '0;
    while (b < n && c < 400) begin
      bus.m_ready = (mode == 0) || (c % 4 == 0) || (c % 4 == 3);
      if (mode == 0) check("no_bubble", bus.m_valid, 1);
      if (stalled) begin
        check("hold_data", $unsigned(bus.m_data), pd);
        check("hold_pos", {bus.m_row, bus.m_col}, prc);
      end
      if (bus.m_valid) begin
        if (bus.m_ready) begin
          if (exp_d.size() == 0) begin
            check("extra_beat", 1, 0);
          end else begin
            check("data", $unsigned(bus.m_data), exp_d.pop_front());
            check("sat", bus.m_sat, exp_s.pop_front());
          end
          check("row", bus.m_row, (b % E) / N);
          check("col", bus.m_col, (b % E) % N);
          check("last", bus.m_last, (b % E) == E - 1);
          b++;
          stalled = 0;
        end else begin
          stalled = 1;
          pd = $unsigned(bus.m_data);
          prc = {bus.m_row, bus.m_col};
        end
      end
      c++;
      step();
    end
    bus.m_ready = 1'b0;
    if (b < n) check("drain_timeout", b, n);
  endtask

  initial begin
    int wrap_exp [5] = '{1, 2, 3, 0, 1};
    rst = 1'b1;
    bus.cap_valid = 1'b0;
    bus.m_ready = 1'b0;
    bus.mat_in = '0;
    step();
    do_reset();

    // basic drain
    fill(6);
    elems[0] = 68; elems[1] = 34; elems[4] = 36; elems[5] = 48;
    for (int k = 0; k < E; k++) push_exp(16'(elems[k]), 1'b0);
    capture();
    check("lat_m_valid", bus.m_valid, 1);
    check("lat_busy", busy, 1);
    check("lat_first", $unsigned(bus.m_data), 68);
    drain(16, 0);
    check("basic_cnt", frame_count, 1);
    check("basic_busy", busy, 0);
    check("basic_valid", bus.m_valid, 0);

    // backpressure
    for (int k = 0; k < E; k++) push_exp(16'(elems[k]), 1'b0);
    capture();
    drain(16, 1);
    check("bp_cnt", frame_count, 2);
    check("bp_queue_empty", exp_d.size(), 0);

    // ping-pong
    do_reset();
    fill(1); push_all(1); capture();
    fill(2); push_all(2); capture();
    fill(9);
    bus.mat_in = pack();
    bus.cap_valid = 1'b1;
    #1;
    check("pp_full_ready", bus.cap_ready, 0);
    step();
    check("pp_full_ready2", bus.cap_ready, 0);
    check("pp_busy", busy, 1);
    bus.cap_valid = 1'b0;
    drain(16, 0);
    check("pp_ready_back", bus.cap_ready, 1);
    drain(16, 0);
    check("pp_cnt", frame_count, 2);
    check("pp_busy_end", busy, 0);

    // saturation
    do_reset();
    fill(0);
    elems[0] = 40000; elems[1] = -40000; elems[2] = 32767; elems[3] = -32768;
    elems[4] = 32'hFFFF_FFFF;
    push_exp(16'h7FFF, 1'b1);
    push_exp(16'h8000, 1'b1);
    push_exp(16'h7FFF, 1'b0);
    push_exp(16'h8000, 1'b0);
    push_exp(16'hFFFF, 1'b0);
    for (int k = 5; k < E; k++) push_exp(16'h0000, 1'b0);
    capture();
    drain(16, 0);

    // reset mid-stream with second bank full
    fill(3); push_all(3); capture();
    fill(4); capture();
    drain(5, 0);
    rst = 1'b1;
    bus.cap_valid = 1'b1;
    #1;
    check("mid_rst_valid", bus.m_valid, 0);
    check("mid_rst_ready", bus.cap_ready, 0);
    step();
    check("mid_rst_valid2", bus.m_valid, 0);
    rst = 1'b0;
    bus.cap_valid = 1'b0;
    #1;
    check("mid_rst_cnt", frame_count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid3", bus.m_valid, 0);
    exp_d.delete();
    exp_s.delete();
    for (int k = 0; k < E; k++) begin
      elems[k] = 100 + k;
      push_exp(16'(100 + k), 1'b0);
    end
    capture();
    check("mid_first", $unsigned(bus.m_data), 100);
    drain(16, 0);
    check("mid_cnt", frame_count, 1);

    // frame counter wrap
    do_reset();
    for (int f = 0; f < 5; f++) begin
      fill(f + 10);
      push_all(f + 10);
      capture();
      drain(16, 0);
      check("wrap_cnt", frame_count, wrap_exp[f]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
Reader side of the systolic array result interface. It snapshots the flattened accumulator matrix (M*N words of ACC_W) on a capture handshake and holds it in a two-bank ping-pong buffer. Each element is streamed out row-major on a valid/ready stream, saturated to OUT_W, with row/col tags and a last flag. It sits between the systolic array and the downstream writeback/DMA path, and can accept the next matrix while the previous one drains.

Parameters:
ACC_W, 32, accumulator width of each matrix element (signed two's complement)
M, 4, array rows
N, 4, array columns
OUT_W, 16, output element width; must be 2..ACC_W; signed saturation when less than ACC_W
CNT_W, 16, width of the frame counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
cap_valid  in  1  upstream asserts when mat_in holds a complete result matrix
cap_ready  out  1  a bank is free and the snapshot will be taken this edge
mat_in  in  M*N*ACC_W  element k=r*N+c at bits [k*ACC_W +: ACC_W]
m_data  out  OUT_W  saturated element value
m_valid  out  1  output element valid
m_ready  in  1  downstream accepts the element
m_row  out  max(1,$clog2(M))  row index of m_data
m_col  out  max(1,$clog2(N))  column index of m_data
m_last  out  1  high with element (M-1,N-1)
m_sat  out  1  high when the current m_data was clipped
busy  out  1  at least one bank is full
frame_count  out  CNT_W  matrices fully drained since reset; wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=1 at an edge): both bank-full flags cleared; wr_ptr=0, rd_ptr=0, element index=0, frame_count=0. While rst is high: cap_ready=0, m_valid=0, m_last=0, m_sat=0, busy=0. m_data, m_row and m_col read 0.
- Reset mid-stream discards both banks. No partial frame completes, and frame_count is not incremented.
- Capture: cap_ready = !rst && !full[wr_ptr] (combinational). A capture occurs on an edge where cap_valid && cap_ready. It copies all of mat_in into bank[wr_ptr], sets full[wr_ptr] and toggles wr_ptr. With cap_valid=0, mat_in is ignored.
- Stream: m_valid = full[rd_ptr]. m_data, m_row, m_col, m_last and m_sat are decoded from bank[rd_ptr][idx] and are purely a function of registers.
- Latency: a capture at edge t gives m_valid=1 in the cycle after t when that bank is next to drain.
- A transfer occurs on an edge where m_valid && m_ready. It advances idx row-major (col first, then row).
- When the transferred element is the last one, idx returns to 0, full[rd_ptr] is cleared, rd_ptr toggles and frame_count increments.
- Outputs are held stable while m_valid && !m_ready.
- m_ready while m_valid=0 has no effect.
- Simultaneous capture into one bank and last-element release of the other in the same edge: both take effect independently. Sustained throughput is one element per cycle with no bubble between frames.
- Both banks full: cap_ready=0 until the last element of the draining bank transfers. cap_ready rises in the following cycle.
- Saturation, with v signed ACC_W:
  - v > 2^(OUT_W-1)-1 gives 2^(OUT_W-1)-1, m_sat=1.
  - v < -2^(OUT_W-1) gives -2^(OUT_W-1), m_sat=1.
  - Otherwise m_data = v[OUT_W-1:0], m_sat=0.
  - OUT_W==ACC_W is a pass-through with m_sat=0.
- busy = full[0] | full[1].
- frame_count wraps from 2^CNT_W-1 to 0.

Test Plan:
- Basic drain: after reset, capture a matrix with elem(0,0)=68, (0,1)=34, (1,0)=36, (1,1)=48, all others 6; hold m_ready=1. Expect m_valid one cycle after capture and 16 beats in order 68,34,6,6,36,48,6,... with correct row/col. m_last only on beat 16 (row 3, col 3); frame_count=1; busy drops the cycle after.
- Backpressure: same matrix, m_ready toggling 1,0,0,1 repeating. Expect each element held unchanged while stalled, no drops or duplicates, 16 beats total.
- Ping-pong: capture A (all 1), then capture B (all 2) one cycle later. Then assert cap_valid again, with m_ready=0. Expect cap_ready=0 on the third request. After release, 16 ones then 16 twos back-to-back with no bubble, and frame_count=2.
- Saturation, OUT_W=16: elements 40000, -40000, 32767, -32768, 0xFFFFFFFF. Expect 32767/sat=1, -32768/sat=1, 32767/sat=0, -32768/sat=0, -1/sat=0.
- Reset mid-stream: assert rst after beat 5 of a frame with the second bank full. Expect m_valid=0, cap_ready=0 during reset, frame_count=0 and busy=0 after. The next capture streams from index 0.
- Frame counter wrap, CNT_W=2: drain 5 frames. Expect frame_count sequence 1,2,3,0,1.
